soc_mem_arbiter: RTL

//  Parametrised N-master to 1-slave memory arbiter for the rv32ima SoC.

---
 rtl/soc_mem_arbiter_pkg.sv | 14 +
 rtl/soc_mem_arbiter_rr_arbiter.sv | 29 ++
 rtl/soc_mem_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/soc_mem_arbiter_pkg.sv
// Shared types and helpers for the N-master memory arbiter.
// Imported by the arbiter top and its round-robin core.
package soc_mem_arbiter_pkg;

    typedef enum logic {
        LK_FREE,
        LK_OWNED
    } lock_state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/soc_mem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins.
// Emits a one-hot grant, or zero when nobody requests.
module soc_mem_arbiter_rr_arbiter
    import soc_mem_arbiter_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = id_width(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt
);

    always_comb begin
        int idx;
        logic found;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/soc_mem_arbiter.sv
// N-master to 1-slave memory arbiter: round-robin, AMO lock,
// and an in-order tagged response pipe of fixed read latency.
module soc_mem_arbiter
    import soc_mem_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS  = 4,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_MASTERS-1:0]          m_req_i,
    input  logic [NUM_MASTERS-1:0]          m_lock_i,
    input  logic [NUM_MASTERS-1:0]          m_we_i,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr_i,
    input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata_i,
    input  logic [NUM_MASTERS*DATA_W/8-1:0] m_be_i,
    output logic [NUM_MASTERS-1:0]          m_gnt_o,
    output logic [NUM_MASTERS-1:0]          m_rvalid_o,
    output logic [DATA_W-1:0]               m_rdata_o,
    input  logic                            mem_ready_i,
    output logic                            mem_req_o,
    output logic                            mem_we_o,
    output logic [ADDR_W-1:0]               mem_addr_o,
    output logic [DATA_W-1:0]               mem_wdata_o,
    output logic [DATA_W/8-1:0]             mem_be_o,
    input  logic [DATA_W-1:0]               mem_rdata_i
);

    localparam int N   = NUM_MASTERS;
    localparam int IDW = id_width(NUM_MASTERS);
    localparam int BEW = DATA_W / 8;
    localparam int LAT = READ_LATENCY;

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } rsp_t;

    lock_state_t    lock_q, lock_d;
    logic [N-1:0]   owner_q, owner_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    rsp_t [LAT-1:0] pipe_q;

    logic [N-1:0]   elig;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] win_id;
    logic           any_gnt;
    logic           win_lock;
    logic           push_rd;

    // Grants are suppressed while reset is held, not only after it.
    always_comb begin
        elig = '0;
        if (!rst_i && mem_ready_i) begin
            elig = (lock_q == LK_OWNED) ? (m_req_i & owner_q) : m_req_i;
        end
    end

    soc_mem_arbiter_rr_arbiter #(
        .N   (N),
        .IDW (IDW)
    ) u_rr (
        .req (elig),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    always_comb begin
        win_id      = '0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        for (int k = 0; k < N; k++) begin
            if (gnt[k]) begin
                win_id      = IDW'(k);
                mem_we_o    = m_we_i[k];
                mem_addr_o  = m_addr_i[k*ADDR_W +: ADDR_W];
                mem_wdata_o = m_wdata_i[k*DATA_W +: DATA_W];
                mem_be_o    = m_be_i[k*BEW +: BEW];
            end
        end
    end

    assign any_gnt   = |gnt;
    assign win_lock  = |(gnt & m_lock_i);
    assign push_rd   = |(gnt & ~m_we_i);
    assign m_gnt_o   = gnt;
    assign mem_req_o = any_gnt;
    assign m_rdata_o = mem_rdata_i;

    // Locked grants keep the pointer; the releasing grant moves it on.
    always_comb begin
        ptr_d = ptr_q;
        if (any_gnt && !win_lock) begin
            ptr_d = (int'(win_id) == N - 1) ? '0 : win_id + 1'b1;
        end
    end

    always_comb begin
        lock_d  = lock_q;
        owner_d = owner_q;
        unique case (lock_q)
            LK_FREE: begin
                if (win_lock) begin
                    lock_d  = LK_OWNED;
                    owner_d = gnt;
                end
            end
            LK_OWNED: begin
                if (!(|(m_req_i & owner_q)) ||
                    (any_gnt && !win_lock)) begin
                    lock_d  = LK_FREE;
                    owner_d = '0;
                end
            end
            default: begin
                lock_d  = LK_FREE;
                owner_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_q  <= LK_FREE;
            owner_q <= '0;
            ptr_q   <= '0;
            pipe_q  <= '0;
        end else begin
            lock_q        <= lock_d;
            owner_q       <= owner_d;
            ptr_q         <= ptr_d;
            pipe_q[0].vld <= push_rd;
            pipe_q[0].id  <= win_id;
            for (int i = 1; i < LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    always_comb begin
        m_rvalid_o = '0;
        if (pipe_q[LAT-1].vld) begin
            m_rvalid_o[pipe_q[LAT-1].id] = 1'b1;
        end
    end

endmodule
